// File: rtl/textlcd_monitor.sv
// rtl/textlcd_monitor.sv - receive-side HD44780-style LCD write-bus model
// Mirrors a 2x16 DDRAM image and mode flags from sampled lcd_e/rs/rw/data.
module textlcd_monitor #(
  parameter int          CLR_CYC = 16,
  parameter logic [7:0]  BLANK   = 8'h20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lcd_e,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [7:0]   lcd_data,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic [6:0]   ac,
  output logic         disp_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         inc,
  output logic         shift,
  output logic         two_line,
  output logic         font5x10,
  output logic         bus8,
  output logic         busy,
  output logic         err_ovr,
  output logic         err_addr
);

  localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            e_d1_q, e_d2_q, rs_d1_q, rw_d1_q;
  logic [7:0]      dat_d1_q;
  logic [127:0]    line1_q, line1_d, line2_q, line2_d;
  logic [6:0]      ac_q, ac_d;
  logic            disp_on_q, disp_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
  logic            inc_q, inc_d, shift_q, shift_d;
  logic            two_line_q, two_line_d, font5x10_q, font5x10_d, bus8_q, bus8_d;
  logic            err_ovr_q, err_ovr_d, err_addr_q, err_addr_d;
  logic            strobe;

  // The two visible DDRAM windows are 0x00-0x27 and 0x40-0x67; ac walks them as one ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line1_d     = line1_q;
    line2_d     = line2_q;
    ac_d        = ac_q;
    disp_on_d   = disp_on_q;
    cursor_on_d = cursor_on_q;
    blink_on_d  = blink_on_q;
    inc_d       = inc_q;
    shift_d     = shift_q;
    two_line_d  = two_line_q;
    font5x10_d  = font5x10_q;
    bus8_d      = bus8_q;
    err_ovr_d   = 1'b0;
    err_addr_d  = 1'b0;
    strobe      = e_d1_q & ~e_d2_q & ~rw_d1_q;

    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (rs_d1_q) begin
            for (int i = 0; i < 16; i++) begin
              if (ac_q[3:0] == 4'(i)) begin
                if (ac_q[6:4] == 3'b000)      line1_d[8*(15-i) +: 8] = dat_d1_q;
                else if (ac_q[6:4] == 3'b100) line2_d[8*(15-i) +: 8] = dat_d1_q;
              end
            end
            ac_d = ac_step(ac_q, inc_q);
          end else begin
            casez (dat_d1_q)
              8'b1???????: begin
                if (addr_ok(dat_d1_q[6:0])) ac_d = dat_d1_q[6:0];
                else                        err_addr_d = 1'b1;
              end
              8'b01??????: ;
              8'b001?????: begin
                bus8_d     = dat_d1_q[4];
                two_line_d = dat_d1_q[3];
                font5x10_d = dat_d1_q[2];
              end
              8'b0001????: begin
                if (!dat_d1_q[3]) ac_d = ac_step(ac_q, dat_d1_q[2]);
              end
              8'b00001???: begin
                disp_on_d   = dat_d1_q[2];
                cursor_on_d = dat_d1_q[1];
                blink_on_d  = dat_d1_q[0];
              end
              8'b000001??: begin
                inc_d   = dat_d1_q[1];
                shift_d = dat_d1_q[0];
              end
              8'b0000001?: begin
                ac_d    = 7'h00;
                state_d = BUSY;
                cnt_d   = CW'(CLR_CYC - 1);
              end
              8'b00000001: begin
                line1_d = {16{BLANK}};
                line2_d = {16{BLANK}};
                ac_d    = 7'h00;
                inc_d   = 1'b1;
                state_d = BUSY;
                cnt_d   = CW'(CLR_CYC - 1);
              end
              default: ;
            endcase
          end
        end
      end
      BUSY: begin
        if (strobe) err_ovr_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      e_d1_q      <= 1'b0;
      e_d2_q      <= 1'b0;
      rs_d1_q     <= 1'b0;
      rw_d1_q     <= 1'b0;
      dat_d1_q    <= 8'h00;
      line1_q     <= {16{BLANK}};
      line2_q     <= {16{BLANK}};
      ac_q        <= 7'h00;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      inc_q       <= 1'b1;
      shift_q     <= 1'b0;
      two_line_q  <= 1'b0;
      font5x10_q  <= 1'b0;
      bus8_q      <= 1'b0;
      err_ovr_q   <= 1'b0;
      err_addr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      e_d1_q      <= lcd_e;
      e_d2_q      <= e_d1_q;
      rs_d1_q     <= lcd_rs;
      rw_d1_q     <= lcd_rw;
      dat_d1_q    <= lcd_data;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      ac_q        <= ac_d;
      disp_on_q   <= disp_on_d;
      cursor_on_q <= cursor_on_d;
      blink_on_q  <= blink_on_d;
      inc_q       <= inc_d;
      shift_q     <= shift_d;
      two_line_q  <= two_line_d;
      font5x10_q  <= font5x10_d;
      bus8_q      <= bus8_d;
      err_ovr_q   <= err_ovr_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign line1     = line1_q;
  assign line2     = line2_q;
  assign ac        = ac_q;
  assign disp_on   = disp_on_q;
  assign cursor_on = cursor_on_q;
  assign blink_on  = blink_on_q;
  assign inc       = inc_q;
  assign shift     = shift_q;
  assign two_line  = two_line_q;
  assign font5x10  = font5x10_q;
  assign bus8      = bus8_q;
  assign busy      = (state_q == BUSY);
  assign err_ovr   = err_ovr_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_textlcd_monitor.sv
// tb/tb_textlcd_monitor.sv - directed self-checking bench for textlcd_monitor
module tb_textlcd_monitor;
  logic         clk = 1'b0;
  logic         rst;
  logic         lcd_e, lcd_rs, lcd_rw;
  logic [7:0]   lcd_data;
  logic [127:0] line1, line2;
  logic [6:0]   ac;
  logic         disp_on, cursor_on, blink_on, inc, shift, two_line, font5x10, bus8;
  logic         busy, err_ovr, err_addr;

  int total = 0;
  int bad   = 0;
  int ovr, adr, bcnt;
  logic [127:0] blank_line;

  textlcd_monitor dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .line1(line1), .line2(line2), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc(inc), .shift(shift), .two_line(two_line), .font5x10(font5x10),
    .bus8(bus8), .busy(busy), .err_ovr(err_ovr), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; e high for 2 clk, low for 2 clk; counts err pulse cycles seen.
  task automatic strobe(input logic rw, input logic rs, input logic [7:0] d,
                        output int o, output int a);
    o = 0;
    a = 0;
    lcd_rw   = rw;
    lcd_rs   = rs;
    lcd_data = d;
    lcd_e    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) lcd_e = 1'b0;
      if (err_ovr) o++;
      if (err_addr) a++;
    end
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk(tag, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    blank_line = {16{8'h20}};
    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_line1", line1, blank_line);
    chk("rst_line2", line2, blank_line);
    chk("rst_ac", {121'd0, ac}, 128'd0);
    chk("rst_inc", {127'd0, inc}, 128'd1);
    chk("rst_flags", {120'd0, disp_on, cursor_on, blink_on, shift, two_line, font5x10, bus8, busy}, 128'd0);

    strobe(0, 0, 8'h3C, ovr, adr);
    strobe(0, 0, 8'h0C, ovr, adr);
    strobe(0, 0, 8'h06, ovr, adr);
    chk("init_fs", {125'd0, bus8, two_line, font5x10}, 128'h7);
    chk("init_dc", {125'd0, disp_on, cursor_on, blink_on}, 128'h4);
    chk("init_em", {126'd0, inc, shift}, 128'h2);
    chk("init_err", {126'd0, err_ovr, err_addr}, 128'd0);

    strobe(0, 0, 8'h80, ovr, adr);
    strobe(0, 1, "H", ovr, adr);
    strobe(0, 1, "E", ovr, adr);
    strobe(0, 1, "L", ovr, adr);
    strobe(0, 1, "L", ovr, adr);
    strobe(0, 1, "O", ovr, adr);
    chk("hello", {88'd0, line1[127:88]}, 128'h48454C4C4F);
    chk("hello_ac", {121'd0, ac}, 128'h05);
    strobe(1, 1, "R", ovr, adr);
    chk("read_ignored", {121'd0, ac}, 128'h05);

    strobe(0, 0, 8'hC0, ovr, adr);
    strobe(0, 1, "W", ovr, adr);
    chk("row2_w", {120'd0, line2[127:120]}, 128'h57);
    chk("row2_ac", {121'd0, ac}, 128'h41);

    strobe(0, 0, 8'hA7, ovr, adr);
    strobe(0, 1, "A", ovr, adr);
    strobe(0, 1, "B", ovr, adr);
    chk("wrap_b", {120'd0, line2[127:120]}, 128'h42);
    chk("wrap_l1", {88'd0, line1[127:88]}, 128'h48454C4C4F);
    chk("wrap_ac", {121'd0, ac}, 128'h41);

    strobe(0, 0, 8'h04, ovr, adr);
    strobe(0, 0, 8'h80, ovr, adr);
    strobe(0, 1, "Z", ovr, adr);
    chk("dec_z", {88'd0, line1[127:88]}, 128'h5A454C4C4F);
    chk("dec_ac", {121'd0, ac}, 128'h67);

    strobe(0, 0, 8'h06, ovr, adr);
    strobe(0, 0, 8'hCF, ovr, adr);
    strobe(0, 1, "X", ovr, adr);
    chk("col16", {120'd0, line2[7:0]}, 128'h58);
    chk("col16_ac", {121'd0, ac}, 128'h50);

    strobe(0, 0, 8'hE7, ovr, adr);
    strobe(0, 0, 8'h14, ovr, adr);
    chk("shr_wrap", {121'd0, ac}, 128'h00);
    strobe(0, 0, 8'h10, ovr, adr);
    chk("shl_wrap", {121'd0, ac}, 128'h67);
    strobe(0, 0, 8'h18, ovr, adr);
    chk("dshift_nop", {121'd0, ac}, 128'h67);
    strobe(0, 0, 8'h45, ovr, adr);
    chk("cgram_ac", {121'd0, ac}, 128'h67);
    chk("cgram_err", {96'd0, 32'(ovr + adr)}, 128'd0);

    // Clear: count busy cycles while driving the strobe by hand.
    strobe(0, 0, 8'h04, ovr, adr);
    lcd_rs = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) lcd_e = 1'b0;
      if (busy) bcnt++;
    end
    chk("clr_busy_len", {96'd0, 32'(bcnt)}, 128'd16);
    chk("clr_line1", line1, blank_line);
    chk("clr_line2", line2, blank_line);
    chk("clr_ac_inc", {120'd0, ac, inc}, 128'h01);

    strobe(0, 0, 8'h01, ovr, adr);
    chk("clr2_busy", {127'd0, busy}, 128'd1);
    strobe(0, 1, "Q", ovr, adr);
    chk("ovr_pulse", {96'd0, 32'(ovr)}, 128'd1);
    chk("ovr_no_addr", {96'd0, 32'(adr)}, 128'd0);
    chk("ovr_nochg", line1, blank_line);
    wait_idle("busy_timeout");
    strobe(0, 1, "Q", ovr, adr);
    chk("after_busy_q", {120'd0, line1[127:120]}, 128'h51);
    chk("after_busy_ac", {121'd0, ac}, 128'h01);

    strobe(0, 0, 8'hB0, ovr, adr);
    chk("addr_pulse", {96'd0, 32'(adr)}, 128'd1);
    chk("addr_no_ovr", {96'd0, 32'(ovr)}, 128'd0);
    chk("addr_ac", {121'd0, ac}, 128'h01);

    strobe(0, 0, 8'h02, ovr, adr);
    chk("home_busy", {127'd0, busy}, 128'd1);
    chk("home_ac", {121'd0, ac}, 128'h00);
    chk("home_chars", {120'd0, line1[127:120]}, 128'h51);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {127'd0, busy}, 128'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stay_idle", {127'd0, busy}, 128'd0);
    chk("rst_mid_line1", line1, blank_line);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
